// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, default widths and
// the mem_RW encodings.
package mem_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int BUS_ADDR_W      = 16;
  localparam int CNT_W           = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Wait counts beyond the counter's reach saturate rather than wrap.
  function automatic logic [CNT_W-1:0] wait_load(input int cycles);
    if (cycles > (2**CNT_W) - 1) begin
      return {CNT_W{1'b1}};
    end else if (cycles < 0) begin
      return '0;
    end
    return CNT_W'(cycles);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write, registered read. Contents are
// never reset; only the read register is.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              rclr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // The read register holds its value until the next completed read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rclr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Four-phase memory responder with configurable wait states.
// Optional out-of-range detection is enabled by defining MEM_RANGE_CHECK_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_EN,
  input  logic                  mem_RW,
  input  logic [BUS_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  MFC,
  output logic                  busy,
  output logic                  mem_err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               rw_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               err_q;
  logic               mfc_q;
  logic               err_flag_q;

  logic               capture;
  logic               access;
  logic               cnt_dec;
  logic               mem_we;
  logic               mem_re;
  logic               mem_rclr;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    access  = 1'b0;
    cnt_dec = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_EN) begin
          capture = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!mem_EN) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ACK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACK: begin
        if (!mem_EN) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rw_q       <= RW_WRITE;
      wdata_q    <= '0;
      mfc_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mfc_q      <= (state_d == ACK);
      err_flag_q <= (state_d == ACK) && (capture ? 1'b0 : err_q);
      if (capture) begin
        cnt_q   <= WAIT_LOAD;
        addr_q  <= addr[ADDR_W-1:0];
        rw_q    <= mem_RW;
        wdata_q <= wdata;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  // An address with any bit above the implemented range is flagged at capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= |addr[BUS_ADDR_W-1:ADDR_W];
    end
  end
`else
  logic unused_hi_addr;
  assign unused_hi_addr = ^addr[BUS_ADDR_W-1:ADDR_W];
  assign err_q          = 1'b0;
`endif

  // Out-of-range accesses still complete but never touch the array.
  assign mem_we   = access && (rw_q == RW_WRITE) && !err_q;
  assign mem_re   = access && (rw_q == RW_READ)  && !err_q;
  assign mem_rclr = access && (rw_q == RW_READ)  &&  err_q;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .rclr  (mem_rclr),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  assign MFC     = mfc_q;
  assign mem_err = err_flag_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, 16, memory word and bus width in bits.
REQ-002 Parameter ADDR_W, 8, implemented address bits; depth is 2**ADDR_W words.
REQ-003 Parameter WAIT_CYCLES, 2, extra wait states before completion; legal range 0..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 mem_EN  input  1  request strobe from the load/store FSM; held high until MFC is seen.
REQ-007 mem_RW  input  1  access type: 1 = read (load), 0 = write (store).
REQ-008 addr  input  16  address from MAR.
REQ-009 wdata  input  DATA_W  store data from MDR.
REQ-010 rdata  output  DATA_W  load data to MDR.
REQ-011 MFC  output  1  memory-function-complete acknowledge.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 mem_err  output  1  range error flag; valid while MFC=1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, ACK.
REQ-015 In IDLE, mem_EN=1 sampled at edge N SHALL latch addr, mem_RW and wdata, load the wait counter with WAIT_CYCLES and enter WAIT.
REQ-016 In WAIT, each edge with mem_EN=1 SHALL decrement the counter. At the edge where the counter is 0, the access SHALL be performed and the FSM SHALL enter ACK. MFC therefore rises after edge N+WAIT_CYCLES+1.
REQ-017 A write SHALL commit the latched wdata to the latched address at the edge that enters ACK.
REQ-018 A read SHALL load rdata at the edge that enters ACK. rdata SHALL then hold its value until the next completed read or reset.
REQ-019 MFC SHALL be registered and SHALL be 1 exactly while in ACK.
REQ-020 In ACK, mem_EN=1 SHALL hold ACK. mem_EN=0 SHALL return the FSM to IDLE with MFC=0 after that edge (four-phase handshake).
REQ-021 mem_EN=0 sampled in WAIT SHALL abort the access: return to IDLE, no write, rdata unchanged, MFC never asserted.
REQ-022 Changes on addr, mem_RW or wdata after the capture edge SHALL be ignored until the next IDLE capture.
REQ-023 A new request SHALL only be accepted from IDLE. mem_EN must be sampled low for at least one edge between requests.
REQ-024 The counter SHALL be 4 bits wide. WAIT_CYCLES=0 SHALL give MFC one edge after capture.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, MFC=0, busy=0, mem_err=0, rdata=0 and counter=0.
REQ-026 Reset during WAIT SHALL cancel the access with no write. Memory array contents SHALL NOT be reset.

Configuration
REQ-027 With MEM_RANGE_CHECK_EN defined, a captured addr with any of bits [15:ADDR_W] nonzero SHALL complete normally with mem_err=1 in ACK. Its write SHALL be suppressed and its read SHALL return rdata=0.
REQ-028 Without MEM_RANGE_CHECK_EN, addr[15:ADDR_W] SHALL be ignored (aliasing) and mem_err SHALL be tied 0. The port SHALL remain present.

Structure
REQ-029 The state encoding, the default width constants and the mem_RW encodings (READ=1, WRITE=0) SHALL live in the shared package mem_pkg.
REQ-030 Storage SHALL be a sub-module mem_array: synchronous write, registered read, no reset on contents.

Verification
REQ-031 Write 16'hBEEF to 8'h05 with WAIT_CYCLES=2, mem_EN held -> MFC rises three edges after capture; busy=1 throughout; MFC falls one edge after mem_EN drops.
REQ-032 Read 8'h05 after REQ-031 -> rdata=16'hBEEF when MFC rises; rdata still BEEF after mem_EN=0 and MFC=0.
REQ-033 Drop mem_EN one edge into WAIT during a write of 16'h1234 to 8'h05 -> MFC stays 0, FSM returns to IDLE, a later read of 8'h05 returns 16'hBEEF.
REQ-034 Assert rst=0 mid-WAIT of a write -> MFC=0, busy=0, rdata=0 immediately; a later read shows the old contents.
REQ-035 With MEM_RANGE_CHECK_EN, write to 16'h0105 -> MFC with mem_err=1; a read of 8'h05 still returns 16'hBEEF. Without the macro, the same write overwrites 8'h05.
REQ-036 With WAIT_CYCLES=0, back-to-back requests separated by one mem_EN-low edge -> each MFC rises one edge after capture, and no request is lost.
